// File: rtl/alu_sat_adder_pkg.sv
// alu_sat_adder_pkg
// Shared ALU constants and types for the saturating adder pipeline.
//   LANE_W / WORD_W : byte-lane and full-word widths
//   LANE_LO/LANE_HI : bit positions inside the 2-bit msb/ovf vectors,
//                     ordered {lane low, lane high} as the saturation
//                     blocks expect
//   s1_t            : stage-1 pipeline register contents
package alu_sat_adder_pkg;

    localparam int LANE_W  = 8;
    localparam int WORD_W  = 16;
    localparam int LANE_LO = 1;
    localparam int LANE_HI = 0;

    typedef struct packed {
        logic              vld;
        logic [LANE_W-1:0] sum_lo;
        logic              v_l;
        logic [LANE_W-1:0] a_hi;
        logic [LANE_W-1:0] b_hi;      // already inverted on subtract
        logic              cin_hi;
        logic              byte_mode;
        logic              sat_en;
    } s1_t;

endpackage

// File: rtl/alu_sat_adder_if.sv
// alu_sat_adder_if
// Operand/result bundle for the saturating adder.
//   master : issues operands and pipeline control, observes results
//   slave  : the adder itself
// Inputs : in_valid, a, b, sub, byte_mode, sat_en, stall, sat_clr
// Outputs: out_valid, sum, msb {f7,f15}, ovf {V_l,V_h}, sat_flag
interface alu_sat_adder_if;
    import alu_sat_adder_pkg::*;

    logic              in_valid;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              sub;
    logic              byte_mode;
    logic              sat_en;
    logic              stall;
    logic              sat_clr;
    logic              out_valid;
    logic [WORD_W-1:0] sum;
    logic [1:0]        msb;
    logic [1:0]        ovf;
    logic              sat_flag;

    modport master (
        output in_valid, a, b, sub, byte_mode, sat_en, stall, sat_clr,
        input  out_valid, sum, msb, ovf, sat_flag
    );

    modport slave (
        input  in_valid, a, b, sub, byte_mode, sat_en, stall, sat_clr,
        output out_valid, sum, msb, ovf, sat_flag
    );

endinterface

// File: rtl/alu_sat_adder_lane_add8.sv
// lane_add8
// Combinational 8-bit adder lane with carry-in.
//   a, b : lane operands (b already in effective, possibly inverted, form)
//   cin  : lane carry-in
//   sum  : wrapped lane sum
//   cout : carry out of bit 7
//   ovf  : signed overflow of this lane
module lane_add8
    import alu_sat_adder_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              cin,
    output logic [LANE_W-1:0] sum,
    output logic              cout,
    output logic              ovf
);

    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{LANE_W{1'b0}}, cin};
        // Same-sign operands producing a different-sign result.
        ovf = (a[LANE_W-1] == b[LANE_W-1]) && (sum[LANE_W-1] != a[LANE_W-1]);
    end

endmodule

// File: rtl/alu_sat_adder.sv
// alu_sat_adder
// Two-stage pipelined 16-bit add/subtract with per-lane sign/overflow flags
// for the byte/word saturation blocks, plus a sticky saturation status bit.
// Stage 1 adds the low byte; stage 2 adds the high byte using either the
// real carry (word mode) or a fresh lane carry-in (packed byte mode).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (priority over stall/sat_clr)
//   bus  : alu_sat_adder_if.slave (operands, control, results, sat_flag)
module alu_sat_adder
    import alu_sat_adder_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    alu_sat_adder_if.slave  bus
);

    s1_t               s1_q, s1_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] sum_q, sum_d;
    logic [1:0]        msb_q, msb_d;
    logic [1:0]        ovf_q, ovf_d;
    logic              s2_byte_q, s2_byte_d;
    logic              s2_sat_en_q, s2_sat_en_d;
    logic              sat_flag_q, sat_flag_d;

    logic [WORD_W-1:0] b_eff;
    logic [LANE_W-1:0] lo_sum, hi_sum;
    logic              lo_cout, lo_ovf, hi_cout, hi_ovf;
    logic              sat_hit;

    // Subtract is A + ~B + 1; the +1 enters each lane via its carry-in.
    assign b_eff = bus.sub ? ~bus.b : bus.b;

    lane_add8 u_lane_lo (
        .a    (bus.a[LANE_W-1:0]),
        .b    (b_eff[LANE_W-1:0]),
        .cin  (bus.sub),
        .sum  (lo_sum),
        .cout (lo_cout),
        .ovf  (lo_ovf)
    );

    lane_add8 u_lane_hi (
        .a    (s1_q.a_hi),
        .b    (s1_q.b_hi),
        .cin  (s1_q.cin_hi),
        .sum  (hi_sum),
        .cout (hi_cout),
        .ovf  (hi_ovf)
    );

    always_comb begin
        s1_d        = s1_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        msb_d       = msb_q;
        ovf_d       = ovf_q;
        s2_byte_d   = s2_byte_q;
        s2_sat_en_d = s2_sat_en_q;

        if (!bus.stall) begin
            s1_d.vld       = bus.in_valid;
            s1_d.sum_lo    = lo_sum;
            s1_d.v_l       = lo_ovf;
            s1_d.a_hi      = bus.a[WORD_W-1:LANE_W];
            s1_d.b_hi      = b_eff[WORD_W-1:LANE_W];
            // Packed mode cuts the bit-7 carry and restarts the lane.
            s1_d.cin_hi    = bus.byte_mode ? bus.sub : lo_cout;
            s1_d.byte_mode = bus.byte_mode;
            s1_d.sat_en    = bus.sat_en;

            out_valid_d      = s1_q.vld;
            sum_d            = {hi_sum, s1_q.sum_lo};
            msb_d[LANE_LO]   = s1_q.sum_lo[LANE_W-1];
            msb_d[LANE_HI]   = hi_sum[LANE_W-1];
            ovf_d[LANE_LO]   = s1_q.v_l;
            ovf_d[LANE_HI]   = hi_ovf;
            s2_byte_d        = s1_q.byte_mode;
            s2_sat_en_d      = s1_q.sat_en;
        end

        // Low-lane overflow only matters in packed mode; a stalled
        // output is not yet consumed so it cannot set the flag.
        sat_hit = out_valid_q && s2_sat_en_q && !bus.stall &&
                  (s2_byte_q ? (ovf_q[LANE_LO] | ovf_q[LANE_HI]) : ovf_q[LANE_HI]);

        if (sat_hit)          sat_flag_d = 1'b1;
        else if (bus.sat_clr) sat_flag_d = 1'b0;
        else                  sat_flag_d = sat_flag_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            msb_q       <= '0;
            ovf_q       <= '0;
            s2_byte_q   <= 1'b0;
            s2_sat_en_q <= 1'b0;
            sat_flag_q  <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            msb_q       <= msb_d;
            ovf_q       <= ovf_d;
            s2_byte_q   <= s2_byte_d;
            s2_sat_en_q <= s2_sat_en_d;
            sat_flag_q  <= sat_flag_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.msb       = msb_q;
    assign bus.ovf       = ovf_q;
    assign bus.sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_alu_sat_adder.sv
// tb_alu_sat_adder
// Directed bench with a result scoreboard: every accepted operation pushes
// the model's expected result; a negedge monitor pops on each fresh output.
module tb_alu_sat_adder;
    import alu_sat_adder_pkg::*;

    typedef struct packed {
        logic [15:0] sum;
        logic [1:0]  msb;
        logic [1:0]  ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_sat_adder_if bus ();

    alu_sat_adder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    int   n_out    = 0;
    exp_t sbq[$];
    logic stall_prev = 1'b1;
    logic rst_prev   = 1'b1;

    // Signed-integer reference: lanes as 8-bit signed, word as 16-bit signed.
    function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic sub, logic bm);
        exp_t e;
        int ra, rb, r, rl, rh;
        logic [15:0] s;
        ra = $signed(a[7:0]);
        rb = $signed(b[7:0]);
        rl = sub ? ra - rb : ra + rb;
        e.ovf[1] = (rl > 127) || (rl < -128);
        if (bm) begin
            ra = $signed(a[15:8]);
            rb = $signed(b[15:8]);
            rh = sub ? ra - rb : ra + rb;
            s  = {rh[7:0], rl[7:0]};
            e.ovf[0] = (rh > 127) || (rh < -128);
        end else begin
            ra = $signed(a);
            rb = $signed(b);
            r  = sub ? ra - rb : ra + rb;
            s  = r[15:0];
            e.ovf[0] = (r > 32767) || (r < -32768);
        end
        e.sum = s;
        e.msb = {s[7], s[15]};
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        stall_prev = bus.stall;
        rst_prev   = rst;
    end

    // Output only updates on an edge with neither stall nor reset.
    always @(negedge clk) begin
        if (!rst_prev && !stall_prev && bus.out_valid === 1'b1) begin
            checks++;
            assert (sbq.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_output got=%0h exp=none", bus.sum);
            end
            if (sbq.size() > 0) begin
                exp_t e;
                e = sbq.pop_front();
                n_out++;
                chk("sum", bus.sum, e.sum);
                chk("msb", bus.msb, e.msb);
                chk("ovf", bus.ovf, e.ovf);
            end
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(logic [15:0] a, logic [15:0] b, logic sub, logic bm, logic se);
        bus.a         = a;
        bus.b         = b;
        bus.sub       = sub;
        bus.byte_mode = bm;
        bus.sat_en    = se;
        bus.in_valid  = 1'b1;
        if (!bus.stall && !rst) sbq.push_back(model(a, b, sub, bm));
        idle(1);
        bus.in_valid  = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sbq.size() > 0 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        checks++;
        assert (sbq.size() == 0) else begin
            failures++;
            $error("FAIL drain_timeout got=%0d exp=0", sbq.size());
        end
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0;
        bus.byte_mode = 1'b0; bus.sat_en = 1'b0; bus.stall = 1'b0; bus.sat_clr = 1'b0;
        idle(2);
        rst = 1'b0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum",       bus.sum,       0);
        chk("rst_msb",       bus.msb,       0);
        chk("rst_ovf",       bus.ovf,       0);
        chk("rst_sat_flag",  bus.sat_flag,  0);

        // Byte add overflow in the low lane, saturating.
        issue(16'h007F, 16'h0001, 1'b0, 1'b1, 1'b1);
        idle(1);
        @(negedge clk);
        chk("latency_valid", bus.out_valid, 1);
        chk("sat_not_yet",   bus.sat_flag,  0);
        idle(1);
        chk("sat_set",       bus.sat_flag,  1);

        bus.sat_clr = 1'b1;
        idle(1);
        bus.sat_clr = 1'b0;
        chk("sat_clr", bus.sat_flag, 0);

        // Carry isolation: byte vs word with the same operands, no sat_en.
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        drain();
        idle(1);
        chk("sat_en0_no_set", bus.sat_flag, 0);

        // Subtracts.
        issue(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
        issue(16'h8000, 16'h0100, 1'b1, 1'b1, 1'b0);
        drain();

        // Word mode ignores low-lane overflow for the sticky flag.
        issue(16'h007F, 16'h0001, 1'b0, 1'b0, 1'b1);
        drain();
        idle(1);
        chk("word_lo_ignored", bus.sat_flag, 0);

        // Set beats clear.
        issue(16'h007F, 16'h0001, 1'b0, 1'b1, 1'b1);
        idle(2);
        chk("sat_set2", bus.sat_flag, 1);
        issue(16'h7F00, 16'h0100, 1'b0, 1'b1, 1'b1);
        idle(1);
        bus.sat_clr = 1'b1;
        idle(1);
        bus.sat_clr = 1'b0;
        chk("set_wins", bus.sat_flag, 1);
        bus.sat_clr = 1'b1;
        idle(1);
        bus.sat_clr = 1'b0;
        chk("clr_alone", bus.sat_flag, 0);

        // Stream of four with a two-cycle stall after op 2.
        n0 = n_out;
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        issue(16'hF0F0, 16'h0F0F, 1'b1, 1'b1, 1'b0);
        bus.stall = 1'b1;
        issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        issue(16'h7F7F, 16'h0101, 1'b0, 1'b1, 1'b1);
        chk("stall_hold_vld", bus.out_valid, 1);
        chk("stall_hold_sum", bus.sum, 16'h8000);
        chk("stall_no_set",   bus.sat_flag, 0);
        bus.stall = 1'b0;
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
        issue(16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b0);
        drain();
        chk("stream_count", n_out - n0, 4);
        chk("sat_after_stall", bus.sat_flag, 1);

        // Reset with operations in flight.
        issue(16'h007F, 16'h0001, 1'b0, 1'b1, 1'b1);
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        sbq.delete();
        n0 = n_out;
        chk("rst_mid_valid", bus.out_valid, 0);
        chk("rst_mid_sat",   bus.sat_flag,  0);
        chk("rst_mid_sum",   bus.sum,       0);
        idle(4);
        chk("rst_flushed", n_out - n0, 0);
        chk("rst_mid_valid2", bus.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
